spi_receive_con: RTL and testbench

SPI_RECEIVE_CON -- requirements
Module: spi_receive_con

---
 rtl/spi_receive_con.sv | 121 ++++++++++++
 tb/tb_spi_receive_con.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_receive_con.sv
// spi_receive_con: resynchronises a nibble-wide SPI-like pixel stream into bytes with row/column tracking and frame checks
module spi_receive_con #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = DATA_WIDTH / 2,
  parameter int H_PIXELS   = 320,
  parameter int V_PIXELS   = 180
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [LINES-1:0]      chip_data_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  input  logic                  final_pixel_in,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid_out,
  output logic [9:0]            hcount_out,
  output logic [8:0]            vcount_out,
  output logic                  frame_done_out,
  output logic                  frame_error_out,
  output logic                  busy_out
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  state_t state, state_nx;
  logic [1:0] clk_sy, sel_sy, fin_sy;
  logic [LINES-1:0] dat_sy1, dat_sy2, hi_nib;
  logic clk_hist, sel_hist;
  logic rise, sel_fall, sel_rise;
  logic cap_hi, emit, abort;
  logic fin_hold, stb_q, err_q, fin_q;
  logic [DATA_WIDTH-1:0] byte_q;
  logic [9:0] hcnt, h_nx;
  logic [8:0] vcnt, v_nx;
  logic h_end, v_end;
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      clk_sy   <= '0;
      sel_sy   <= '1;
      fin_sy   <= '0;
      dat_sy1  <= '0;
      dat_sy2  <= '0;
      clk_hist <= 1'b0;
      sel_hist <= 1'b1;
    end else begin
      clk_sy   <= {clk_sy[0], chip_clk_in};
      sel_sy   <= {sel_sy[0], chip_sel_in};
      fin_sy   <= {fin_sy[0], final_pixel_in};
      dat_sy1  <= chip_data_in;
      dat_sy2  <= dat_sy1;
      clk_hist <= clk_sy[1];
      sel_hist <= sel_sy[1];
    end
  assign rise     = clk_sy[1] & ~clk_hist & ~sel_sy[1];
  assign sel_fall = sel_hist & ~sel_sy[1];
  assign sel_rise = ~sel_hist & sel_sy[1];
  assign busy_out = ~sel_sy[1];
  always_comb begin
    state_nx = state;
    cap_hi   = 1'b0;
    emit     = 1'b0;
    abort    = 1'b0;
    if (sel_fall) begin
      state_nx = WAIT_HI;
      abort    = state == WAIT_LO;
    end else if (state == WAIT_HI) begin
      state_nx = sel_rise ? IDLE : rise ? WAIT_LO : WAIT_HI;
      cap_hi   = rise;
    end else if (state == WAIT_LO) begin
      state_nx = (sel_rise | rise) ? IDLE : WAIT_LO;
      abort    = sel_rise;
      emit     = rise;
    end
  end
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      state    <= IDLE;
      hi_nib   <= '0;
      fin_hold <= 1'b0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
      byte_q   <= '0;
    end else begin
      state <= state_nx;
      stb_q <= emit;
      err_q <= abort;
      if (cap_hi) begin
        hi_nib   <= dat_sy2;
        fin_hold <= fin_sy[1];
      end
      if (emit) begin
        byte_q <= {hi_nib, dat_sy2};
        fin_q  <= fin_hold;
      end
    end
  assign h_end = hcnt == 10'(H_PIXELS - 1);
  assign v_end = vcnt == 9'(V_PIXELS - 1);
  assign h_nx  = (fin_q | h_end) ? '0 : hcnt + 10'd1;
  assign v_nx  = fin_q ? '0 : h_end ? (v_end ? '0 : vcnt + 9'd1) : vcnt;
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      hcnt            <= '0;
      vcnt            <= '0;
    end else begin
      pixel_valid_out <= stb_q;
      frame_done_out  <= stb_q & fin_q;
      frame_error_out <= err_q | (stb_q & (fin_q ^ (h_end & v_end)));
      if (stb_q) begin
        pixel_out  <= byte_q;
        hcount_out <= hcnt;
        vcount_out <= vcnt;
        hcnt       <= h_nx;
        vcnt       <= v_nx;
      end
    end
endmodule

// File: tb/tb_spi_receive_con.sv
// tb_spi_receive_con: directed self-checking bench for spi_receive_con
module tb_spi_receive_con;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [3:0] chip_data_in = '0;
  logic chip_clk_in = 1'b0;
  logic chip_sel_in = 1'b1;
  logic final_pixel_in = 1'b0;
  logic [7:0] pixel_out;
  logic pixel_valid_out;
  logic [9:0] hcount_out;
  logic [8:0] vcount_out;
  logic frame_done_out;
  logic frame_error_out;
  logic busy_out;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_done = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int l_h = 0;
  int l_v = 0;
  int l_pix = 0;
  int l_done = 0;
  int l_err = 0;
  int e0, v0, d0, r0;
  always #5 clk_in = ~clk_in;
  spi_receive_con #(.H_PIXELS(320), .V_PIXELS(3)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .chip_data_in(chip_data_in),
    .chip_clk_in(chip_clk_in),
    .chip_sel_in(chip_sel_in),
    .final_pixel_in(final_pixel_in),
    .pixel_out(pixel_out),
    .pixel_valid_out(pixel_valid_out),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .frame_done_out(frame_done_out),
    .frame_error_out(frame_error_out),
    .busy_out(busy_out)
  );
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) begin
    if (pixel_valid_out) begin
      n_valid = n_valid + 1;
      valid_cyc = cyc;
      l_pix = int'(pixel_out);
      l_h = int'(hcount_out);
      l_v = int'(vcount_out);
      l_done = int'(frame_done_out);
      l_err = int'(frame_error_out);
    end
    if (frame_done_out) n_done = n_done + 1;
    if (frame_error_out) n_err = n_err + 1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic snap();
    v0 = n_valid;
    d0 = n_done;
    r0 = n_err;
  endtask
  task automatic do_reset();
    rst_n_in = 1'b0;
    tick(5);
    rst_n_in = 1'b1;
    tick(3);
  endtask
  task automatic send(input logic [7:0] b, input logic fin, input int half);
    chip_sel_in = 1'b0;
    tick(3);
    chip_data_in = b[7:4];
    final_pixel_in = fin;
    tick(half);
    chip_clk_in = 1'b1;
    tick(half);
    chip_clk_in = 1'b0;
    chip_data_in = b[3:0];
    tick(half);
    chip_clk_in = 1'b1;
    e0 = cyc + 1;
    tick(half);
    chip_clk_in = 1'b0;
    final_pixel_in = 1'b0;
    chip_sel_in = 1'b1;
    tick(3);
  endtask
  task automatic first_nibble(input logic [3:0] n);
    chip_sel_in = 1'b0;
    tick(3);
    chip_data_in = n;
    tick(4);
    chip_clk_in = 1'b1;
    tick(4);
    chip_clk_in = 1'b0;
    tick(4);
  endtask
  initial begin
    tick(5);
    chk("rst_pix", int'(pixel_out), 0);
    chk("rst_h", int'(hcount_out), 0);
    chk("rst_v", int'(vcount_out), 0);
    chk("rst_valid", int'(pixel_valid_out), 0);
    chk("rst_done", int'(frame_done_out), 0);
    chk("rst_err", int'(frame_error_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    rst_n_in = 1'b1;
    tick(3);
    snap();
    send(8'hA5, 1'b0, 50);
    tick(5);
    chk("a5_count", n_valid - v0, 1);
    chk("a5_pix", l_pix, 'hA5);
    chk("a5_h", l_h, 0);
    chk("a5_v", l_v, 0);
    chk("a5_latency", valid_cyc - e0, 3);
    chk("a5_err", n_err - r0, 0);
    tick(20);
    chk("hold_pix", int'(pixel_out), 'hA5);
    chk("hold_valid", int'(pixel_valid_out), 0);
    snap();
    chip_sel_in = 1'b0;
    tick(5);
    chk("busy_hi", int'(busy_out), 1);
    chip_sel_in = 1'b1;
    tick(5);
    chk("busy_lo", int'(busy_out), 0);
    chk("empty_valid", n_valid - v0, 0);
    chk("empty_err", n_err - r0, 0);
    do_reset();
    snap();
    for (int i = 0; i < 320; i++) send(i[7:0], 1'b0, 4);
    tick(5);
    chk("row_count", n_valid - v0, 320);
    chk("row_last_h", l_h, 319);
    chk("row_last_v", l_v, 0);
    chk("row_last_pix", l_pix, 'h3F);
    send(8'h77, 1'b0, 4);
    tick(5);
    chk("row_next_h", l_h, 0);
    chk("row_next_v", l_v, 1);
    chk("row_err", n_err - r0, 0);
    do_reset();
    snap();
    for (int i = 0; i < 650; i++) send(i[7:0], 1'b0, 4);
    send(8'hEE, 1'b1, 4);
    tick(5);
    chk("early_h", l_h, 10);
    chk("early_v", l_v, 2);
    chk("early_done", l_done, 1);
    chk("early_err", l_err, 1);
    chk("early_done_cnt", n_done - d0, 1);
    chk("early_err_cnt", n_err - r0, 1);
    send(8'h11, 1'b0, 4);
    tick(5);
    chk("early_next_h", l_h, 0);
    chk("early_next_v", l_v, 0);
    chk("early_next_done", l_done, 0);
    do_reset();
    snap();
    for (int i = 0; i < 959; i++) send(i[7:0], 1'b0, 4);
    send(8'hF0, 1'b1, 4);
    tick(5);
    chk("frame_h", l_h, 319);
    chk("frame_v", l_v, 2);
    chk("frame_done", l_done, 1);
    chk("frame_err_flag", l_err, 0);
    chk("frame_done_cnt", n_done - d0, 1);
    chk("frame_err_cnt", n_err - r0, 0);
    send(8'h22, 1'b0, 4);
    tick(5);
    chk("frame_next_h", l_h, 0);
    chk("frame_next_v", l_v, 0);
    chk("frame_next_pix", l_pix, 'h22);
    snap();
    first_nibble(4'h9);
    chip_sel_in = 1'b1;
    tick(8);
    chk("abort_valid", n_valid - v0, 0);
    chk("abort_err", n_err - r0, 1);
    send(8'h5A, 1'b0, 4);
    tick(5);
    chk("abort_next_pix", l_pix, 'h5A);
    chk("abort_next_h", l_h, 1);
    chk("abort_next_v", l_v, 0);
    first_nibble(4'h6);
    rst_n_in = 1'b0;
    chip_sel_in = 1'b1;
    tick(5);
    rst_n_in = 1'b1;
    tick(5);
    snap();
    chk("rstmid_idle", n_valid - v0, 0);
    send(8'h3C, 1'b0, 4);
    tick(5);
    chk("rstmid_count", n_valid - v0, 1);
    chk("rstmid_pix", l_pix, 'h3C);
    chk("rstmid_h", l_h, 0);
    chk("rstmid_v", l_v, 0);
    chk("rstmid_err", n_err - r0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
